// File: rtl/n2tl_prb_rxq_if.sv
// Channel-B probe queue bus: decoder push side, probe FSM handshake and status.
interface n2tl_prb_rxq_if #(
  parameter int unsigned AW = 2
) ();
  logic          rx_b_valid;
  logic [2:0]    rx_b_opcode;
  logic [1:0]    rx_b_param;
  logic [3:0]    rx_b_size;
  logic [25:0]   rx_b_source;
  logic [63:0]   rx_b_address;
  logic          rx_b_ready;
  logic          probe_req;
  logic          probe_req_ack;
  logic          probe_req_done;
  logic [1:0]    b_param;
  logic [3:0]    b_size;
  logic [25:0]   b_source;
  logic [63:0]   b_address;
  logic [AW:0]   q_count;
  logic [15:0]   bad_op_cnt;

  modport master (
    output rx_b_valid, rx_b_opcode, rx_b_param, rx_b_size, rx_b_source,
           rx_b_address, probe_req_ack, probe_req_done,
    input  rx_b_ready, probe_req, b_param, b_size, b_source, b_address,
           q_count, bad_op_cnt
  );

  modport slave (
    input  rx_b_valid, rx_b_opcode, rx_b_param, rx_b_size, rx_b_source,
           rx_b_address, probe_req_ack, probe_req_done,
    output rx_b_ready, probe_req, b_param, b_size, b_source, b_address,
           q_count, bad_op_cnt
  );
endinterface

// File: rtl/n2tl_prb_rxq.sv
// Channel-B Probe receive queue: buffers decoded Probes, presents the head
// entry to the probe FSM one at a time and drops/counts non-Probe opcodes.
// The head is retired on the edge that enters Q_POP, so occupancy drops the
// cycle after probe_req_done while Q_POP still holds probe_req low.
module n2tl_prb_rxq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset_,
  n2tl_prb_rxq_if.slave bus
);

  localparam logic [2:0]  OP_PROBE = 3'd6;
  localparam logic [15:0] BAD_MAX  = 16'hFFFF;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]  param;
    logic [3:0]  size;
    logic [25:0] source;
    logic [63:0] address;
  } probe_ent_t;

  typedef enum logic [3:0] {
    Q_IDLE = 4'b0001,
    Q_REQ  = 4'b0010,
    Q_BUSY = 4'b0100,
    Q_POP  = 4'b1000
  } q_state_e;

  q_state_e      r_state;
  q_state_e      w_state_nxt;
  probe_ent_t    r_mem [DEPTH];
  probe_ent_t    r_b;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_probe_req;
  logic [15:0]   r_bad_op_cnt;
  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_bad;
  logic          w_load;
  logic          w_pop;
  logic          w_req_nxt;
  probe_ent_t    w_rx_ent;

  assign w_ready  = (r_count != CNT_FULL);
  assign w_accept = bus.rx_b_valid & w_ready;
  assign w_push   = w_accept & (bus.rx_b_opcode == OP_PROBE);
  assign w_bad    = w_accept & (bus.rx_b_opcode != OP_PROBE);
  assign w_rx_ent = '{param:   bus.rx_b_param,
                      size:    bus.rx_b_size,
                      source:  bus.rx_b_source,
                      address: bus.rx_b_address};

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_state <= Q_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Q_IDLE: if (r_count != '0) w_state_nxt = Q_REQ;
      Q_REQ: begin
        if (bus.probe_req_ack && bus.probe_req_done) w_state_nxt = Q_POP;
        else if (bus.probe_req_ack)                  w_state_nxt = Q_BUSY;
      end
      Q_BUSY: if (bus.probe_req_done) w_state_nxt = Q_POP;
      Q_POP:  w_state_nxt = Q_IDLE;
      default: w_state_nxt = Q_IDLE;
    endcase
  end

  // FSM outputs: head load, head retire and next probe_req level
  always_comb begin
    w_load    = 1'b0;
    w_pop     = 1'b0;
    w_req_nxt = 1'b0;
    if ((r_state == Q_IDLE) && (w_state_nxt == Q_REQ)) w_load = 1'b1;
    if ((r_state != Q_POP) && (w_state_nxt == Q_POP))  w_pop  = 1'b1;
    if (w_state_nxt == Q_REQ)                          w_req_nxt = 1'b1;
  end

  // Entry storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_rx_ent;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered request level and head fields, frozen until the next load
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_probe_req <= 1'b0;
      r_b         <= '0;
    end else begin
      r_probe_req <= w_req_nxt;
      if (w_load) r_b <= r_mem[r_head];
    end
  end

  // Saturating count of dropped non-Probe opcodes
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                                r_bad_op_cnt <= '0;
    else if (w_bad && (r_bad_op_cnt != BAD_MAX)) r_bad_op_cnt <= r_bad_op_cnt + 16'd1;
  end

  assign bus.rx_b_ready = w_ready;
  assign bus.probe_req  = r_probe_req;
  assign bus.b_param    = r_b.param;
  assign bus.b_size     = r_b.size;
  assign bus.b_source   = r_b.source;
  assign bus.b_address  = r_b.address;
  assign bus.q_count    = r_count;
  assign bus.bad_op_cnt = r_bad_op_cnt;

endmodule

// File: tb/tb_n2tl_prb_rxq.sv
// Bench for the channel-B probe receive queue: directed vector table, corner
// sequences, randomized traffic against a queue model, counter saturation.
module tb_n2tl_prb_rxq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int          NV    = 15;

  logic clk = 1'b0;
  logic reset_;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  n2tl_prb_rxq_if #(.AW(AW)) bus ();

  n2tl_prb_rxq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [95:0] in_b;
    logic        ack;
    logic        done;
    logic        e_req;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [15:0] e_bad;
    logic        chk_b;
    logic [95:0] e_b;
  } vec_t;

  vec_t vec [NV];

  function automatic logic [95:0] cur_b();
    return {bus.b_param, bus.b_size, bus.b_source, bus.b_address};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [2:0] op, input logic [95:0] e,
                       input logic ack, input logic done);
    bus.rx_b_valid     = valid;
    bus.rx_b_opcode    = op;
    bus.rx_b_param     = e[95:94];
    bus.rx_b_size      = e[93:90];
    bus.rx_b_source    = e[89:64];
    bus.rx_b_address   = e[63:0];
    bus.probe_req_ack  = ack;
    bus.probe_req_done = done;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 96'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset_ = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  // Act as the probe FSM for one entry: wait for probe_req, check head, ack, done
  task automatic serve(input string nm, input logic [95:0] exp_b, input bit together);
    int t;
    t = 0;
    while (bus.probe_req !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_req"}, 128'(bus.probe_req), 128'(1'b1));
    check({nm, "_b"}, 128'(cur_b()), 128'(exp_b));
    bus.probe_req_ack  = 1'b1;
    bus.probe_req_done = together;
    @(negedge clk);
    bus.probe_req_ack  = 1'b0;
    bus.probe_req_done = 1'b0;
    if (!together) begin
      bus.probe_req_done = 1'b1;
      @(negedge clk);
      bus.probe_req_done = 1'b0;
    end
  endtask

  logic [95:0] fill_b [5];
  logic [95:0] mq [$];
  logic [95:0] pa, pb, pz, ent;
  logic        v, a, d;
  logic [2:0]  op;
  int          m_bad, phase, gap, wait_cnt;
  bit          do_pop;

  initial begin
    pa = {2'd2, 4'd6, 26'h15, 64'h8000_0040};
    pb = {2'd1, 4'd3, 26'h2A, 64'h0000_1000};
    pz = '0;
    // valid op in_b ack done | req cnt rdy bad chk_b e_b
    vec[0]  = '{1'b1, 3'd6, pa, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'd0, 1'b0, pz};
    vec[1]  = '{1'b0, 3'd0, pz, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 16'd0, 1'b1, pa};
    vec[2]  = '{1'b0, 3'd0, pz, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 16'd0, 1'b1, pa};
    vec[3]  = '{1'b0, 3'd0, pz, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'd0, 1'b1, pa};
    vec[4]  = '{1'b0, 3'd0, pz, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd0, 1'b1, pa};
    vec[5]  = '{1'b0, 3'd0, pz, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0, 1'b1, pa};
    vec[6]  = '{1'b1, 3'd4, pz, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd1, 1'b0, pz};
    vec[7]  = '{1'b1, 3'd4, pz, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd2, 1'b0, pz};
    vec[8]  = '{1'b1, 3'd4, pz, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd3, 1'b0, pz};
    vec[9]  = '{1'b1, 3'd6, pb, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 16'd3, 1'b0, pz};
    vec[10] = '{1'b0, 3'd0, pz, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 16'd3, 1'b1, pb};
    vec[11] = '{1'b0, 3'd0, pz, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 16'd3, 1'b1, pb};
    vec[12] = '{1'b0, 3'd0, pz, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd3, 1'b1, pb};
    vec[13] = '{1'b0, 3'd0, pz, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 16'd3, 1'b0, pz};
    vec[14] = '{1'b0, 3'd0, pz, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd3, 1'b0, pz};
    for (int k = 0; k < 5; k++)
      fill_b[k] = {2'(k), 4'(k + 2), 26'(32'h100 + k), 64'(64'hA000_0000 + 64'(k) * 64)};

    // Reset state
    reset_ = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("rst_req", 128'(bus.probe_req), 128'(1'b0));
    check("rst_rdy", 128'(bus.rx_b_ready), 128'(1'b1));
    check("rst_cnt", 128'(bus.q_count), 128'(3'd0));
    check("rst_bad", 128'(bus.bad_op_cnt), 128'(16'd0));
    check("rst_b", 128'(cur_b()), 128'(pz));
    reset_ = 1'b1;

    // Directed vector table: single probe, bad opcodes, ack+done together
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].valid, vec[i].op, vec[i].in_b, vec[i].ack, vec[i].done);
      @(negedge clk);
      check($sformatf("vec%0d_req", i), 128'(bus.probe_req), 128'(vec[i].e_req));
      check($sformatf("vec%0d_cnt", i), 128'(bus.q_count), 128'(vec[i].e_cnt));
      check($sformatf("vec%0d_rdy", i), 128'(bus.rx_b_ready), 128'(vec[i].e_rdy));
      check($sformatf("vec%0d_bad", i), 128'(bus.bad_op_cnt), 128'(vec[i].e_bad));
      if (vec[i].chk_b)
        check($sformatf("vec%0d_b", i), 128'(cur_b()), 128'(vec[i].e_b));
    end
    idle();

    // Fill: four accepted, fifth held until a slot frees
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd6, fill_b[k], 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(1'b1, 3'd6, fill_b[4], 1'b0, 1'b0);
    check("fill_rdy0", 128'(bus.rx_b_ready), 128'(1'b0));
    check("fill_cnt4", 128'(bus.q_count), 128'(3'd4));
    repeat (2) @(negedge clk);
    check("fill_hold_cnt", 128'(bus.q_count), 128'(3'd4));
    check("fill_head_req", 128'(bus.probe_req), 128'(1'b1));
    check("fill_head_b", 128'(cur_b()), 128'(fill_b[0]));
    bus.probe_req_ack = 1'b1;
    @(negedge clk);
    bus.probe_req_ack  = 1'b0;
    bus.probe_req_done = 1'b1;
    @(negedge clk);
    bus.probe_req_done = 1'b0;
    check("fill_pop_rdy", 128'(bus.rx_b_ready), 128'(1'b1));
    check("fill_pop_cnt", 128'(bus.q_count), 128'(3'd3));
    @(negedge clk);
    idle();
    check("fill_5th_cnt", 128'(bus.q_count), 128'(3'd4));
    for (int k = 1; k < 5; k++) serve($sformatf("fill_drain%0d", k), fill_b[k], (k % 2) == 0);
    @(negedge clk);
    check("fill_empty", 128'(bus.q_count), 128'(3'd0));

    // Push and pop on the same edge with two entries queued
    drive(1'b1, 3'd6, pa, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd6, pb, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    check("pp_req", 128'(bus.probe_req), 128'(1'b1));
    check("pp_cnt2", 128'(bus.q_count), 128'(3'd2));
    bus.probe_req_ack = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'd6, fill_b[3], 1'b0, 1'b1);
    @(negedge clk);
    idle();
    check("pp_cnt_same", 128'(bus.q_count), 128'(3'd2));
    serve("pp_second", pb, 1'b0);
    serve("pp_third", fill_b[3], 1'b1);
    @(negedge clk);
    check("pp_empty", 128'(bus.q_count), 128'(3'd0));

    // Asynchronous reset while a probe is being serviced
    drive(1'b1, 3'd4, pz, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd6, pa, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd6, pb, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, pz, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    check("mid_cnt2", 128'(bus.q_count), 128'(3'd2));
    #2 reset_ = 1'b0;
    #1;
    check("mid_rst_req", 128'(bus.probe_req), 128'(1'b0));
    check("mid_rst_cnt", 128'(bus.q_count), 128'(3'd0));
    check("mid_rst_rdy", 128'(bus.rx_b_ready), 128'(1'b1));
    check("mid_rst_b", 128'(cur_b()), 128'(pz));
    check("mid_rst_bad", 128'(bus.bad_op_cnt), 128'(16'd0));
    @(negedge clk);
    reset_ = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_after_req", 128'(bus.probe_req), 128'(1'b0));
    check("mid_after_cnt", 128'(bus.q_count), 128'(3'd0));

    // Randomized traffic against an occupancy/FIFO model
    do_reset();
    mq.delete();
    m_bad = 0; phase = 0; gap = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_cnt", 128'(bus.q_count), 128'(mq.size()));
      check("rnd_rdy", 128'(bus.rx_b_ready), 128'(mq.size() != DEPTH));
      check("rnd_bad", 128'(bus.bad_op_cnt), 128'(m_bad));
      if (gap > 0) begin
        check("rnd_gap", 128'(bus.probe_req), 128'(1'b0));
        gap--;
      end
      if (phase == 0 && bus.probe_req === 1'b1) begin
        check("rnd_req_nonempty", 128'(mq.size() != 0), 128'(1'b1));
        if (mq.size() != 0) check("rnd_head", 128'(cur_b()), 128'(mq[0]));
      end
      if (phase == 1) begin
        check("rnd_busy_req", 128'(bus.probe_req), 128'(1'b0));
        if (mq.size() != 0) check("rnd_busy_b", 128'(cur_b()), 128'(mq[0]));
      end
      if (phase == 0 && bus.probe_req !== 1'b1 && mq.size() != 0) begin
        wait_cnt++;
        check("rnd_latency", 128'(wait_cnt <= 2), 128'(1'b1));
      end else begin
        wait_cnt = 0;
      end

      v   = ($urandom % 3) != 0;
      op  = (($urandom % 4) == 0) ? 3'($urandom_range(0, 5)) : 3'd6;
      ent = {2'($urandom), 4'($urandom), 26'($urandom), $urandom, $urandom};
      a = 1'b0; d = 1'b0; do_pop = 1'b0;
      if (phase == 0 && bus.probe_req === 1'b1) begin
        if (($urandom % 2) == 0) begin
          a = 1'b1;
          phase = 1;
          if (($urandom % 3) == 0) begin d = 1'b1; do_pop = 1'b1; end
        end
      end else if (phase == 1) begin
        if (($urandom % 3) == 0) begin d = 1'b1; do_pop = 1'b1; end
      end else begin
        a = ($urandom % 8) == 0;
        d = ($urandom % 8) == 0;
      end
      drive(v, op, ent, a, d);

      if (v && mq.size() != DEPTH) begin
        if (op == 3'd6) begin
          if (do_pop) void'(mq.pop_front());
          mq.push_back(ent);
          do_pop = 1'b0;
        end else if (m_bad != 65535) begin
          m_bad++;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (d && phase == 1) begin
        phase = 0;
        gap = 2;
      end
      @(negedge clk);
    end
    idle();

    // Saturation of the dropped-opcode counter
    do_reset();
    drive(1'b1, 3'd4, pz, 1'b0, 1'b0);
    repeat (65534) @(negedge clk);
    check("sat_fffe", 128'(bus.bad_op_cnt), 128'(16'hFFFE));
    repeat (3) @(negedge clk);
    idle();
    check("sat_ffff", 128'(bus.bad_op_cnt), 128'(16'hFFFF));
    check("sat_cnt", 128'(bus.q_count), 128'(3'd0));
    check("sat_req", 128'(bus.probe_req), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
